// File: rtl/fifo_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_ctrl_pkg : shared FSM encodings and default thresholds               |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package fifo_ctrl_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_RESET  = 3'd0;
  localparam logic [STATE_W-1:0] ST_INIT   = 3'd1;
  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd2;
  localparam logic [STATE_W-1:0] ST_ACTIVE = 3'd3;
  localparam logic [STATE_W-1:0] ST_ERROR  = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    S_RESET  = ST_RESET,
    S_INIT   = ST_INIT,
    S_IDLE   = ST_IDLE,
    S_ACTIVE = ST_ACTIVE,
    S_ERROR  = ST_ERROR
  } state_t;

  localparam int DEF_ALTO_C = 6;
  localparam int DEF_BAJO_C = 1;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_arbiter : one-hot grant to the first requester at or after ptr         |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_idx;
  logic             w_found;

  // Scan ptr, ptr+1, ... modulo N; the extra sum bit makes the wrap work for any N.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (w_sum >= (IDX_W+1)'(N)) begin
        w_sum = w_sum - (IDX_W+1)'(N);
      end
      w_idx = w_sum[IDX_W-1:0];
      if (en && !w_found && req[w_idx]) begin
        w_found      = 1'b1;
        gnt[w_idx]   = 1'b1;
        gnt_idx      = w_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_rd_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_rd_scheduler : threshold config + round-robin pop control for FIFOs  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module fifo_rd_scheduler
  import fifo_ctrl_pkg::*;
#(
  parameter int NUM_FIFOS = 4,
  parameter int MEM_SIZE  = 8,
  parameter int PTR       = 3,
  parameter int DEF_ALTO  = DEF_ALTO_C,
  parameter int DEF_BAJO  = DEF_BAJO_C
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         init,
  input  logic [PTR:0]                 umbral_alto,
  input  logic [PTR:0]                 umbral_bajo,
  input  logic [NUM_FIFOS-1:0]         fifo_empty,
  input  logic [NUM_FIFOS*(PTR+1)-1:0] fifo_occ,
  input  logic [NUM_FIFOS-1:0]         fifo_overflow,
  input  logic                         dest_full,
  output logic [NUM_FIFOS-1:0]         fifo_rd,
  output logic [NUM_FIFOS-1:0]         almost_full,
  output logic [NUM_FIFOS-1:0]         almost_empty,
  output logic [STATE_W-1:0]           state,
  output logic                         idle,
  output logic                         error_out
);

  localparam int IDX_W = $clog2(NUM_FIFOS);

  state_t           r_state;
  state_t           w_state_next;
  logic [PTR:0]     r_alto;
  logic [PTR:0]     r_bajo;
  logic [PTR:0]     w_alto_clamp;
  logic [PTR:0]     w_bajo_clamp;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] w_rr_next;
  logic [IDX_W-1:0] w_gnt_idx;
  logic [NUM_FIFOS-1:0] w_gnt;
  logic             w_any_ovf;
  logic             w_pop_en;
  logic             w_granted;
  logic             w_flags_en;

  assign w_any_ovf    = |fifo_overflow;
  assign w_alto_clamp = (umbral_alto > (PTR+1)'(MEM_SIZE)) ? (PTR+1)'(MEM_SIZE) : umbral_alto;
  assign w_bajo_clamp = (umbral_bajo > w_alto_clamp) ? w_alto_clamp : umbral_bajo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_RESET;
      r_alto   <= (PTR+1)'(DEF_ALTO);
      r_bajo   <= (PTR+1)'(DEF_BAJO);
      r_rr_ptr <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_INIT && init) begin
        r_alto <= w_alto_clamp;
        r_bajo <= w_bajo_clamp;
      end
      if (w_granted) begin
        r_rr_ptr <= w_rr_next;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_RESET:  w_state_next = S_INIT;
      S_INIT:   if (!init) w_state_next = S_IDLE;
      S_IDLE: begin
        if (init)             w_state_next = S_INIT;
        else if (~&fifo_empty) w_state_next = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (init)             w_state_next = S_INIT;
        else if (&fifo_empty) w_state_next = S_IDLE;
      end
      S_ERROR:  w_state_next = S_ERROR;
      default:  w_state_next = S_RESET;
    endcase
    // Overflow outranks every other transition once out of RESET.
    if (r_state != S_RESET && w_any_ovf) begin
      w_state_next = S_ERROR;
    end
  end

  assign w_pop_en = (r_state == S_ACTIVE) && !init && !dest_full && !w_any_ovf;

  rr_arbiter #(
    .N (NUM_FIFOS)
  ) u_arb (
    .req     (~fifo_empty),
    .ptr     (r_rr_ptr),
    .en      (w_pop_en),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  assign w_granted = |w_gnt;
  assign w_rr_next = (w_gnt_idx == IDX_W'(NUM_FIFOS-1)) ? '0 : w_gnt_idx + IDX_W'(1);

  assign fifo_rd    = w_gnt;
  assign state      = r_state;
  assign idle       = (r_state == S_IDLE);
  assign error_out  = (r_state == S_ERROR);
  assign w_flags_en = (r_state != S_RESET);

  for (genvar gi = 0; gi < NUM_FIFOS; gi++) begin : g_flags
    logic [PTR:0] w_occ;
    assign w_occ            = fifo_occ[gi*(PTR+1) +: PTR+1];
    assign almost_full[gi]  = w_flags_en && (w_occ >= r_alto);
    assign almost_empty[gi] = w_flags_en && (w_occ <= r_bajo);
  end

endmodule
`default_nettype wire
